// File: rtl/matrix_load_if.sv
// Dimension/element stream port and packed-matrix result bus between a producer and matrix_load.
// The master side feeds dims and elements; the slave side returns the packed matrix and status.
interface matrix_load_if #(
  parameter int unsigned MAX_DIM = 128,
  parameter int unsigned DW      = 32
) ();
  logic                           start;
  logic [7:0]                     m_dim;
  logic [7:0]                     n_dim;
  logic                           in_valid;
  logic [DW-1:0]                  in_data;
  logic                           in_ready;
  logic [7:0]                     m1_dim;
  logic [7:0]                     n1_dim;
  logic [MAX_DIM*MAX_DIM*DW-1:0]  matrix_out;
  logic                           make;
  logic                           busy;
  logic                           err;

  modport master (
    output start, m_dim, n_dim, in_valid, in_data,
    input  in_ready, m1_dim, n1_dim, matrix_out, make, busy, err
  );

  modport slave (
    input  start, m_dim, n_dim, in_valid, in_data,
    output in_ready, m1_dim, n1_dim, matrix_out, make, busy, err
  );
endinterface

// File: rtl/matrix_load.sv
// Streams row-major matrix elements over valid/ready into a flat packed bus for matrix_make,
// pulsing make once the last element of the latched m x n matrix has been written.
module matrix_load #(
  parameter int unsigned MAX_DIM = 128,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  matrix_load_if.slave  bus
);
  localparam int unsigned NEL = MAX_DIM * MAX_DIM;
  localparam int unsigned IW  = $clog2(NEL) + 1;
  localparam int unsigned MW  = NEL * DW;
  localparam logic [8:0]  DIM_MAX = 9'(MAX_DIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   last_q;
  logic [MW-1:0]   matrix_q;
  logic [7:0]      m1_q;
  logic [7:0]      n1_q;
  logic            ready_q;
  logic            make_q;
  logic            busy_q;
  logic            err_q;

  logic            dims_ok;
  logic [15:0]     total;
  logic [31:0]     wr_base;
  logic            xfer;

  assign dims_ok = (bus.m_dim != 8'd0) && (bus.n_dim != 8'd0) &&
                   ({1'b0, bus.m_dim} <= DIM_MAX) && ({1'b0, bus.n_dim} <= DIM_MAX);
  assign total   = 16'(bus.m_dim) * 16'(bus.n_dim);
  assign wr_base = 32'(idx_q) * DW;
  assign xfer    = bus.in_valid && ready_q;

  // Final element index is fixed when dims are latched, so the per-transfer
  // end test is a plain equality against a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      matrix_q <= '0;
      m1_q     <= '0;
      n1_q     <= '0;
      ready_q  <= 1'b0;
      make_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          make_q <= 1'b0;
          if (bus.start) begin
            if (dims_ok) begin
              m1_q     <= bus.m_dim;
              n1_q     <= bus.n_dim;
              matrix_q <= '0;
              idx_q    <= '0;
              last_q   <= IW'(total - 16'd1);
              err_q    <= 1'b0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            matrix_q[wr_base +: DW] <= bus.in_data;
            idx_q                   <= idx_q + IW'(1);
            if (idx_q == last_q) begin
              ready_q <= 1'b0;
              make_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          make_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          make_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.m1_dim     = m1_q;
  assign bus.n1_dim     = n1_q;
  assign bus.matrix_out = matrix_q;
  assign bus.make       = make_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_matrix_load.sv
// Directed bench for matrix_load (MAX_DIM=4 build): a transaction-level model of the load
// is checked against the DUT every cycle, plus hand-computed literal expectations.
module tb_matrix_load;
  localparam int unsigned MD  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned NEL = MD * MD;
  localparam int unsigned MW  = NEL * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_load_if #(.MAX_DIM(MD), .DW(DW)) bus ();
  matrix_load #(.MAX_DIM(MD), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int make_cnt = 0;
  int make_cyc = -1;
  int start_cyc = 0;
  int last_xfer_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a list of element slots plus a count of elements still owed.
  logic [DW-1:0] exp_mem [NEL];
  int  exp_m = 0, exp_n = 0, remaining = 0, wr = 0;
  bit  exp_done = 0, exp_err = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < NEL; k++) exp_mem[k] = '0;
      exp_m = 0; exp_n = 0; remaining = 0; wr = 0; exp_done = 0; exp_err = 0;
    end else if (exp_done) begin
      exp_done = 0;
    end else if (remaining > 0) begin
      if (bus.in_valid) begin
        exp_mem[wr] = bus.in_data;
        wr++;
        remaining--;
        if (remaining == 0) exp_done = 1;
      end
    end else if (bus.start) begin
      if (int'(bus.m_dim) >= 1 && int'(bus.m_dim) <= MD &&
          int'(bus.n_dim) >= 1 && int'(bus.n_dim) <= MD) begin
        exp_m = int'(bus.m_dim);
        exp_n = int'(bus.n_dim);
        for (int k = 0; k < NEL; k++) exp_mem[k] = '0;
        wr = 0;
        remaining = exp_m * exp_n;
        exp_err = 0;
      end else begin
        exp_err = 1;
      end
    end
  end

  initial forever begin
    logic [MW-1:0] ev;
    @(negedge clk);
    ev = '0;
    for (int k = 0; k < NEL; k++) ev[k*DW +: DW] = exp_mem[k];
    chk("in_ready",   MW'(bus.in_ready), MW'(remaining > 0));
    chk("make",       MW'(bus.make),     MW'(exp_done));
    chk("busy",       MW'(bus.busy),     MW'((remaining > 0) || exp_done));
    chk("err",        MW'(bus.err),      MW'(exp_err));
    chk("m1_dim",     MW'(bus.m1_dim),   MW'(exp_m));
    chk("n1_dim",     MW'(bus.n1_dim),   MW'(exp_n));
    chk("matrix_out", bus.matrix_out,    ev);
    if (bus.make === 1'b1) begin
      make_cnt++;
      make_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int m, input int n);
    bus.start = 1'b1;
    bus.m_dim = 8'(m);
    bus.n_dim = 8'(n);
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    last_xfer_cyc = cyc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (bus.busy !== 1'b1) break;
      tick();
    end
    chk("idle_timeout", MW'(bus.busy), MW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] saved;
    int mc0;
    reset = 1'b1;
    bus.start = 1'b0; bus.m_dim = '0; bus.n_dim = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    tick(); tick();
    chk("rst_matrix", bus.matrix_out, '0);
    chk("rst_busy",   MW'(bus.busy), MW'(0));
    chk("rst_ready",  MW'(bus.in_ready), MW'(0));
    reset = 1'b0;
    tick();

    // 3x2 back-to-back
    mc0 = make_cnt;
    do_start(3, 2);
    for (int i = 1; i <= 6; i++) send(DW'(i));
    wait_idle();
    chk("b32_low",  MW'(bus.matrix_out[191:0]),
        MW'({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
    chk("b32_high", MW'(bus.matrix_out[MW-1:192]), MW'(0));
    chk("b32_m1",   MW'(bus.m1_dim), MW'(3));
    chk("b32_n1",   MW'(bus.n1_dim), MW'(2));
    chk("b32_makes",   MW'(make_cnt - mc0), MW'(1));
    chk("b32_latency", MW'(make_cyc - start_cyc), MW'(7));

    // 2x2 with a bubble after every element
    mc0 = make_cnt;
    do_start(2, 2);
    send(32'd10); tick(); send(32'd20); tick(); send(32'd30); tick(); send(32'd40);
    wait_idle();
    chk("bp_idx3",   MW'(bus.matrix_out[127:96]), MW'(40));
    chk("bp_idx1",   MW'(bus.matrix_out[63:32]),  MW'(20));
    chk("bp_clear",  MW'(bus.matrix_out[191:128]), MW'(0));
    chk("bp_makes",  MW'(make_cnt - mc0), MW'(1));
    chk("bp_make_after_last", MW'(make_cyc - last_xfer_cyc), MW'(1));

    // illegal dims
    saved = bus.matrix_out;
    do_start(0, 4);
    chk("ill0_err",   MW'(bus.err), MW'(1));
    chk("ill0_ready", MW'(bus.in_ready), MW'(0));
    chk("ill0_busy",  MW'(bus.busy), MW'(0));
    tick();
    do_start(129, 1);
    chk("ill129_err", MW'(bus.err), MW'(1));
    do_start(MD + 1, 4);
    chk("illmax_err", MW'(bus.err), MW'(1));
    chk("ill_busy",   MW'(bus.busy), MW'(0));
    chk("ill_keep",   bus.matrix_out, saved);
    chk("ill_m1",     MW'(bus.m1_dim), MW'(2));
    do_start(1, 1);
    chk("legal_clears_err", MW'(bus.err), MW'(0));
    send(32'h55);
    wait_idle();

    // reset during a 4x4 load, with a transfer offered in the same cycle
    mc0 = make_cnt;
    do_start(4, 4);
    for (int i = 1; i <= 5; i++) send(DW'(i));
    bus.in_valid = 1'b1; bus.in_data = 32'd99; reset = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    chk("rmid_matrix", bus.matrix_out, '0);
    chk("rmid_m1",     MW'(bus.m1_dim), MW'(0));
    chk("rmid_busy",   MW'(bus.busy), MW'(0));
    chk("rmid_ready",  MW'(bus.in_ready), MW'(0));
    tick();
    chk("rmid_nomake", MW'(make_cnt - mc0), MW'(0));
    do_start(1, 1);
    send(32'hDEADBEEF);
    wait_idle();
    chk("one_word",    MW'(bus.matrix_out[31:0]), MW'(32'hDEADBEEF));
    chk("one_latency", MW'(make_cyc - start_cyc), MW'(2));

    // spurious start mid-load and on the DONE cycle, then a smaller reload
    do_start(3, 3);
    send(32'd1); send(32'd2);
    bus.start = 1'b1; bus.m_dim = 8'd1; bus.n_dim = 8'd1;
    send(32'd3);
    bus.start = 1'b0;
    for (int i = 4; i <= 9; i++) send(DW'(i));
    do_start(2, 2);
    chk("done_start_ignored", MW'(bus.busy), MW'(0));
    chk("s33_m1",  MW'(bus.m1_dim), MW'(3));
    chk("s33_n1",  MW'(bus.n1_dim), MW'(3));
    chk("s33_el8", MW'(bus.matrix_out[9*DW-1 -: DW]), MW'(9));
    do_start(1, 2);
    send(32'd7); send(32'd8);
    wait_idle();
    chk("r12_low",  MW'(bus.matrix_out[63:0]), MW'({32'd8, 32'd7}));
    chk("r12_high", MW'(bus.matrix_out[MW-1:64]), MW'(0));

    // full MAX_DIM x MAX_DIM
    mc0 = make_cnt;
    do_start(MD, MD);
    for (int i = 1; i <= 16; i++) send(DW'(i));
    wait_idle();
    tick(); tick();
    chk("max_last",  MW'(bus.matrix_out[16*DW-1 -: DW]), MW'(16));
    chk("max_first", MW'(bus.matrix_out[DW-1:0]), MW'(1));
    chk("max_makes", MW'(make_cnt - mc0), MW'(1));

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
